rest_serial: RTL and testbench

Bit-serial two's-complement subtractor with start/done handshake. Computes Diff = A − B − Bin one bit per clock, LSB first, through a single 1-bit full-subtractor cell. It is the subtracting counterpart of the team's ripple-carry adder, and it trades latency for area in the RESTADOR datapath. Results are registered and held until the next accepted operation.

---
 rtl/rest_pkg.sv | 18 +
 rtl/rest1b.sv | 22 ++
 rtl/rest_serial.sv | 112 +++++++++++
 tb/tb_rest_serial.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rest_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rest_pkg
// Brief  : Shared types and constants for the bit-serial subtractor.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package rest_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : rest_pkg
`default_nettype wire

// File: rtl/rest1b.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rest1b
// Brief  : Combinational 1-bit full subtractor, d = a - b - bi.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module rest1b (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   // Difference bit and borrow-out of a single bit position
   always_comb begin
      d  = a ^ b ^ bi;
      bo = (~a & b) | (~(a ^ b) & bi);
   end

endmodule : rest1b
`default_nettype wire

// File: rtl/rest_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rest_serial
// Brief  : Bit-serial two's-complement subtractor, Diff = A - B - Bin,
//          one bit per clock LSB first, with start/busy/done handshake.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module rest_serial
   import rest_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf
);

   localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;

   logic               cell_d;
   logic               cell_bo;
   logic               accept;
   logic               last_bit;
   logic [WIDTH-1:0]   res_shifted;

   // Start is only honoured between operations; in RUN it is ignored
   assign accept      = start && ((state == IDLE) || (state == DONE));
   assign last_bit    = (state == RUN) && (cnt == LAST_BIT);
   assign res_shifted = {cell_d, res_sr[WIDTH-1:1]};

   rest1b u_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .bi (borrow),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Operand shift registers, borrow flop, bit counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         Diff   <= '0;
         Bout   <= 1'b0;
         Ovf    <= 1'b0;
      end else if (accept) begin
         a_sr   <= A;
         b_sr   <= B;
         res_sr <= '0;
         borrow <= Bin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_shifted;
         borrow <= cell_bo;
         cnt    <= cnt + 1'b1;
         // On the last bit the cell inputs are the operand MSBs
         if (last_bit) begin
            Diff <= res_shifted;
            Bout <= cell_bo;
            Ovf  <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
         end
      end
   end

endmodule : rest_serial
`default_nettype wire

// File: tb/tb_rest_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_rest_serial
// Brief  : Scoreboard testbench for rest_serial (WIDTH = 4).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_rest_serial;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A     = '0;
   logic [W-1:0] B     = '0;
   logic         Bin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;
   logic         Ovf;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t sb[$];

   rest_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout),
      .Ovf   (Ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operands
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      exp_t e;
      int   ua, ub, sa, sbv, r;
      ua  = int'(a);
      ub  = int'(b);
      sa  = a[W-1] ? ua - (1 << W) : ua;
      sbv = b[W-1] ? ub - (1 << W) : ub;
      r   = sa - sbv - int'(bin);
      e.a    = a;
      e.b    = b;
      e.bin  = bin;
      e.diff = W'(ua - ub - int'(bin));
      e.bout = (ua < ub + int'(bin));
      e.ovf  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return e;
   endfunction

   // Present operands with a one-cycle start, then scramble the inputs.
   // Returns at the first negedge after the accepting edge (cycle 1).
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      sb.push_back(model(a, b, bin));
      @(negedge clk);
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
   endtask

   // Wait (bounded) for done; reports the cycle index and busy cycles seen
   task automatic wait_done(input int n0, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int n = n0; n <= 40; n++) begin
         if (done) begin
            lat = n;
            return;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, Diff, Bout, Ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                  busy, done, Diff, Bout, Ovf);
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, Diff, Bout, Ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset_release: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                  busy, done, Diff, Bout, Ovf);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] ta [5] = '{4'h7, 4'h3, 4'h8, 4'h7, 4'h0};
      logic [W-1:0] tb [5] = '{4'h3, 4'h7, 4'h1, 4'hF, 4'h0};
      logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int   lat, bcnt;
      exp_t e;
      for (int i = 0; i < 11; i++) begin
         if (i < 5) start_op(ta[i], tb[i], tc[i]);
         else       start_op(W'($urandom), W'($urandom), 1'($urandom));
         wait_done(1, lat, bcnt);
         vectors++;
         if (lat != W + 1 || bcnt != W) begin
            miscompares++;
            $display("FAIL basic_timing op%0d: got done at cycle %0d busy %0d cycles, expected %0d and %0d",
                     i, lat, bcnt, W + 1, W);
         end
         if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL basic_scoreboard op%0d: got done with empty queue, expected one entry", i);
         end else begin
            e = sb.pop_front();
            vectors++;
            if (Diff !== e.diff || Bout !== e.bout || Ovf !== e.ovf) begin
               miscompares++;
               $display("FAIL basic_result %h-%h-%b: got diff=%h bout=%b ovf=%b, expected diff=%h bout=%b ovf=%b",
                        e.a, e.b, e.bin, Diff, Bout, Ovf, e.diff, e.bout, e.ovf);
            end
         end
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse op%0d: got done=%b busy=%b, expected 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_start_in_run();
      int   lat, bcnt;
      exp_t e;
      start_op(4'h5, 4'h5, 1'b1);
      @(negedge clk);
      A = '0; B = '0; Bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, lat, bcnt);
      vectors++;
      if (lat != W + 1) begin
         miscompares++;
         $display("FAIL run_ignore_timing: got done at cycle %0d, expected %0d", lat, W + 1);
      end
      e = sb.pop_front();
      vectors++;
      if (Diff !== e.diff || Bout !== e.bout || Ovf !== e.ovf) begin
         miscompares++;
         $display("FAIL run_ignore_result: got diff=%h bout=%b ovf=%b, expected diff=%h bout=%b ovf=%b",
                  Diff, Bout, Ovf, e.diff, e.bout, e.ovf);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL run_ignore_no_restart: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int           first  = -1;
      int           second = -1;
      bit           hold_ok = 1'b1;
      logic [W-1:0] first_diff = 'x;
      exp_t         e;
      start_op(4'h6, 4'h2, 1'b0);
      for (int n = 1; n <= 30; n++) begin
         if (done) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL b2b_scoreboard: got done at cycle %0d with empty queue, expected one entry", n);
            end else begin
               e = sb.pop_front();
               vectors++;
               if (Diff !== e.diff || Bout !== e.bout || Ovf !== e.ovf) begin
                  miscompares++;
                  $display("FAIL b2b_result %h-%h: got diff=%h bout=%b ovf=%b, expected diff=%h bout=%b ovf=%b",
                           e.a, e.b, Diff, Bout, Ovf, e.diff, e.bout, e.ovf);
               end
            end
            if (first < 0) begin
               first      = n;
               first_diff = Diff;
            end else begin
               second = n;
               break;
            end
         end
         if (first > 0 && n > first && Diff !== first_diff) hold_ok = 1'b0;
         if (n == 4) begin
            A = 4'hF; B = 4'hE; Bin = 1'b0; start = 1'b1;
            sb.push_back(model(4'hF, 4'hE, 1'b0));
         end
         if (first > 0 && n == first + 1) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      vectors++;
      if (first != W + 1 || second != first + W + 1) begin
         miscompares++;
         $display("FAIL b2b_timing: got done at cycles %0d and %0d, expected %0d and %0d",
                  first, second, W + 1, 2 * (W + 1));
      end
      vectors++;
      if (!hold_ok) begin
         miscompares++;
         $display("FAIL b2b_hold: got diff changing before second done, expected it held at %h", first_diff);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int   lat, bcnt;
      bit   saw_done = 1'b0;
      exp_t e;
      start_op(4'h9, 4'h3, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, Diff, Bout, Ovf} !== '0) begin
         miscompares++;
         $display("FAIL abort_clear: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                  busy, done, Diff, Bout, Ovf);
      end
      sb.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (i == 3) rst_n = 1'b1;
      end
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL abort_no_done: got done=1 after aborted op, expected 0");
      end
      start_op(4'hA, 4'h3, 1'b1);
      wait_done(1, lat, bcnt);
      e = sb.pop_front();
      vectors++;
      if (lat != W + 1 || Diff !== e.diff || Bout !== e.bout || Ovf !== e.ovf) begin
         miscompares++;
         $display("FAIL abort_recover: got cycle=%0d diff=%h bout=%b ovf=%b, expected cycle=%0d diff=%h bout=%b ovf=%b",
                  lat, Diff, Bout, Ovf, W + 1, e.diff, e.bout, e.ovf);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_rest_serial
`default_nettype wire
